// File: rtl/vec_strided_lsu.sv
// Strided vector load/store engine (vlse.v / vsse.v): one word-aligned bus access per element,
// loaded elements written to the VRF, stored elements read from it.
module vec_strided_lsu #(
  parameter int unsigned MAX_VL = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_store,
  input  logic [ADDR_W-1:0]       cmd_base,
  input  logic [ADDR_W-1:0]       cmd_stride,
  input  logic [$clog2(MAX_VL):0] cmd_vl,
  input  logic [1:0]              cmd_sew,
  input  logic [4:0]              cmd_vd,
  output logic                    done,
  output logic                    err,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  input  logic [31:0]             mem_rdata,
  output logic                    vrf_we,
  output logic [4:0]              vrf_reg,
  output logic [$clog2(MAX_VL):0] vrf_idx,
  output logic [1:0]              vrf_sew,
  output logic [31:0]             vrf_wdata,
  input  logic [31:0]             vrf_rdata
);

  localparam int unsigned IdxW = $clog2(MAX_VL) + 1;

  typedef enum logic [2:0] {StIdle, StCheck, StAccess, StResp, StFin} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [IdxW-1:0]   vl_q, vl_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        sew_q, sew_d;
  logic [4:0]        vd_q, vd_d;
  logic [31:0]       elem_q, elem_d;
  logic              err_q, err_d;

  logic [31:0] sew_mask;
  logic [3:0]  strb_base;
  logic [4:0]  lane_sh;
  logic        misaligned;

  always_comb begin
    case (sew_q)
      2'd0:    begin sew_mask = 32'h0000_00ff; strb_base = 4'b0001; end
      2'd1:    begin sew_mask = 32'h0000_ffff; strb_base = 4'b0011; end
      2'd2:    begin sew_mask = 32'hffff_ffff; strb_base = 4'b1111; end
      default: begin sew_mask = 32'h0000_0000; strb_base = 4'b0000; end
    endcase
  end

  assign lane_sh    = {addr_q[1:0], 3'b000};
  assign misaligned = (sew_q == 2'd1 && addr_q[0]) || (sew_q == 2'd2 && addr_q[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vl_d     = vl_q;
    idx_d    = idx_q;
    sew_d    = sew_q;
    vd_d     = vd_q;
    elem_d   = elem_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          store_d  = cmd_store;
          addr_d   = cmd_base;
          stride_d = cmd_stride;
          vl_d     = cmd_vl;
          sew_d    = cmd_sew;
          vd_d     = cmd_vd;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        // Alignment is re-checked per element; earlier elements stay committed.
        if (vl_q == '0) begin
          err_d   = 1'b0;
          state_d = StFin;
        end else if (sew_q == 2'd3 || misaligned) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          if (!store_q) elem_d = (mem_rdata >> lane_sh) & sew_mask;
          state_d = StResp;
        end
      end
      StResp: begin
        if (idx_q + IdxW'(1) == vl_q) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          addr_d  = addr_q + stride_q;
          state_d = StCheck;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      idx_q    <= '0;
      sew_q    <= 2'd0;
      vd_q     <= 5'd0;
      elem_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vl_q     <= vl_d;
      idx_q    <= idx_d;
      sew_q    <= sew_d;
      vd_q     <= vd_d;
      elem_q   <= elem_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from state, so a reset drops mem_valid on the very next cycle.
  assign cmd_ready = (state_q == StIdle);
  assign mem_valid = (state_q == StAccess);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = store_q ? ((vrf_rdata & sew_mask) << lane_sh) : 32'd0;
  assign mem_wstrb = (mem_valid && store_q) ? (strb_base << addr_q[1:0]) : 4'b0000;
  assign vrf_we    = (state_q == StResp) && !store_q;
  assign vrf_reg   = vd_q;
  assign vrf_idx   = idx_q;
  assign vrf_sew   = sew_q;
  assign vrf_wdata = elem_q;
  assign done      = (state_q == StFin);
  assign err       = (state_q == StFin) && err_q;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Bench for vec_strided_lsu: directed command table plus random commands checked against a
// byte-level memory/VRF model, with a randomized-latency memory responder.
module tb_vec_strided_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [31:0] cmd_base, cmd_stride;
  logic [5:0]  cmd_vl;
  logic [1:0]  cmd_sew;
  logic [4:0]  cmd_vd;
  logic        done, err;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        vrf_we;
  logic [4:0]  vrf_reg;
  logic [5:0]  vrf_idx;
  logic [1:0]  vrf_sew;
  logic [31:0] vrf_wdata, vrf_rdata;

  always #5 clk = ~clk;

  vec_strided_lsu #(.MAX_VL(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
    .cmd_vd(cmd_vd), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .vrf_we(vrf_we), .vrf_reg(vrf_reg), .vrf_idx(vrf_idx), .vrf_sew(vrf_sew),
    .vrf_wdata(vrf_wdata), .vrf_rdata(vrf_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic [4:0]  rg;
    logic [5:0]  idx;
    logic [1:0]  sew;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic             store;
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [5:0]       vl;
    logic [1:0]       sew;
    logic [4:0]       vd;
    logic             fixed;
    logic             exp_err;
    logic [5:0]       exp_nacc;
    logic [3:0]       exp_lat;
    logic [3:0]       nfa;
    logic [3:0]       nfd;
    logic [3:0]       fstrb;
    logic [7:0][31:0] fa;
    logic [7:0][31:0] fd;
  } vec_t;

  // Environment memory/VRF (seen by the DUT) and the reference model's own copies.
  logic [31:0] env_mem [256];
  logic [31:0] env_vrf [32][32];
  logic [7:0]  ref_mem [1024];
  logic [31:0] ref_vrf [32][32];

  assign vrf_rdata = env_vrf[vrf_reg][vrf_idx[4:0]];

  acc_t obs_acc[$];
  wr_t  obs_wr[$];
  int   done_cnt = 0;
  logic last_err = 1'b0;
  logic hold = 1'b0, in_req = 1'b0, real_rdy = 1'b0;
  int   wait_left = 0;
  logic [7:0] widx;
  int   errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: memory responder just after posedge, monitor at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      if (real_rdy) chk("valid_low_after_ready", 32'(mem_valid), 32'd0);
      real_rdy = 1'b0;
      in_req   = 1'b0;
    end else if (!mem_valid) begin
      in_req = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        mem_rdata = $urandom();
        mem_ready = 1'b1;
      end
    end else if (!hold) begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_left = $urandom_range(0, 3);
      end
      if (wait_left == 0) begin
        widx      = mem_addr[9:2];
        mem_rdata = env_mem[widx];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
        mem_ready = 1'b1;
        real_rdy  = 1'b1;
      end else begin
        wait_left--;
      end
    end
    @(negedge clk);
    if (mem_valid && mem_ready) obs_acc.push_back({mem_addr, mem_wstrb, mem_wdata});
    if (vrf_we) begin
      obs_wr.push_back({vrf_reg, vrf_idx, vrf_sew, vrf_wdata});
      env_vrf[vrf_reg][vrf_idx[4:0]] = vrf_wdata;
    end
    if (done) begin
      done_cnt++;
      last_err = err;
    end
  endtask

  function automatic logic [7:0][31:0] l8(input logic [31:0] a0 = '0, a1 = '0, a2 = '0,
                                          a3 = '0, a4 = '0, a5 = '0, a6 = '0, a7 = '0);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic vec_t mk(input logic st, input logic [31:0] base, input logic [31:0] stride,
                              input int vl, input int sew, input int vd, input int e,
                              input int nacc, input int lat);
    vec_t v;
    v = '0;
    v.store = st; v.base = base; v.stride = stride; v.vl = 6'(vl); v.sew = 2'(sew);
    v.vd = 5'(vd); v.fixed = 1'b1; v.exp_err = e[0]; v.exp_nacc = 6'(nacc);
    v.exp_lat = 4'(lat);
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input string nm);
    acc_t exp_acc[$];
    wr_t  exp_wr[$];
    logic exp_err;
    logic [31:0] a, e, wd;
    logic [3:0]  st;
    int size, lane, acc_base, wr_base, done_base, lat, budget, nacc, nwr, nbad;

    // Reference model: element i lives at base + i*stride, processed until the first bad element.
    exp_err = 1'b0;
    a = v.base;
    size = (v.sew == 2'd0) ? 1 : (v.sew == 2'd1) ? 2 : 4;
    for (int i = 0; i < int'(v.vl); i++) begin
      if (v.sew == 2'd3 || (a & 32'(size - 1)) != 32'd0) begin
        exp_err = 1'b1;
        break;
      end
      lane = int'(a[1:0]);
      wd = '0;
      st = '0;
      e  = '0;
      for (int k = 0; k < size; k++) begin
        if (v.store) begin
          ref_mem[int'(a[9:0]) + k] = ref_vrf[v.vd][i][8*k +: 8];
          wd[8*(lane+k) +: 8] = ref_vrf[v.vd][i][8*k +: 8];
          st[lane+k] = 1'b1;
        end else begin
          e[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
        end
      end
      exp_acc.push_back({a & 32'hffff_fffc, st, wd});
      if (!v.store) begin
        ref_vrf[v.vd][i] = e;
        exp_wr.push_back({v.vd, 6'(i), v.sew, e});
      end
      a = a + v.stride;
    end

    chk({nm, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    acc_base  = obs_acc.size();
    wr_base   = obs_wr.size();
    done_base = done_cnt;
    cmd_store = v.store; cmd_base = v.base; cmd_stride = v.stride;
    cmd_vl = v.vl; cmd_sew = v.sew; cmd_vd = v.vd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    budget = 12 * int'(v.vl) + 20;
    while (done_cnt == done_base && lat < budget) begin
      tick();
      lat++;
    end
    if (done_cnt == done_base) begin
      errors++;
      checks++;
      $display("FAIL %s_done: got no done in %0d cycles, expected one done pulse", nm, budget);
    end else begin
      tick();
      tick();
      chk({nm, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    end

    nacc = obs_acc.size() - acc_base;
    nwr  = obs_wr.size() - wr_base;
    chk({nm, "_err"}, 32'(last_err), 32'(exp_err));
    chk({nm, "_n_access"}, 32'(nacc), 32'(exp_acc.size()));
    chk({nm, "_n_vrf_we"}, 32'(nwr), 32'(exp_wr.size()));
    for (int i = 0; i < nacc && i < exp_acc.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), obs_acc[acc_base+i].addr, exp_acc[i].addr);
      chk($sformatf("%s_strb%0d", nm, i), 32'(obs_acc[acc_base+i].strb), 32'(exp_acc[i].strb));
      if (v.store)
        chk($sformatf("%s_wdata%0d", nm, i), obs_acc[acc_base+i].data, exp_acc[i].data);
    end
    for (int i = 0; i < nwr && i < exp_wr.size(); i++) begin
      chk($sformatf("%s_vrf_tag%0d", nm, i),
          32'({obs_wr[wr_base+i].rg, obs_wr[wr_base+i].idx, obs_wr[wr_base+i].sew}),
          32'({exp_wr[i].rg, exp_wr[i].idx, exp_wr[i].sew}));
      chk($sformatf("%s_vrf_data%0d", nm, i), obs_wr[wr_base+i].data, exp_wr[i].data);
    end
    if (v.store) begin
      nbad = 0;
      for (int w = 0; w < 256; w++)
        for (int b = 0; b < 4; b++)
          if (env_mem[w][8*b +: 8] !== ref_mem[4*w+b]) nbad++;
      chk({nm, "_mem_image_bad_bytes"}, 32'(nbad), 32'd0);
    end

    // Hand-derived expectations from the directed table.
    if (v.fixed) begin
      chk({nm, "_tbl_err"}, 32'(last_err), 32'(v.exp_err));
      chk({nm, "_tbl_n_access"}, 32'(nacc), 32'(v.exp_nacc));
      chk({nm, "_tbl_n_vrf_we"}, 32'(nwr), v.store ? 32'd0 : 32'(v.exp_nacc));
      if (v.exp_lat != 4'd0) chk({nm, "_tbl_latency"}, 32'(lat), 32'(v.exp_lat));
      for (int i = 0; i < int'(v.nfa) && i < nacc; i++) begin
        chk($sformatf("%s_tbl_addr%0d", nm, i), obs_acc[acc_base+i].addr, v.fa[i]);
        if (v.store)
          chk($sformatf("%s_tbl_strb%0d", nm, i), 32'(obs_acc[acc_base+i].strb), 32'(v.fstrb));
      end
      for (int i = 0; i < int'(v.nfd); i++) begin
        if (v.store && i < nacc)
          chk($sformatf("%s_tbl_wdata%0d", nm, i), obs_acc[acc_base+i].data, v.fd[i]);
        else if (!v.store && i < nwr)
          chk($sformatf("%s_tbl_elem%0d", nm, i), obs_wr[wr_base+i].data, v.fd[i]);
      end
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    int nrows, sz, s, r, acc0, wr0, dn0;

    tbl[0] = mk(0, 400, 2, 8, 0, 1, 0, 8, 0);
    tbl[0].nfa = 8; tbl[0].fa = l8(400, 400, 404, 404, 408, 408, 412, 412);
    tbl[0].nfd = 8; tbl[0].fd = l8('h01, 'h03, 'h05, 'h07, 'h09, 'h0b, 'h0d, 'h0f);
    tbl[1] = mk(0, 420, 2, 8, 0, 2, 0, 8, 0);
    tbl[1].nfa = 8; tbl[1].fa = l8(420, 420, 424, 424, 428, 428, 432, 432);
    tbl[1].nfd = 8; tbl[1].fd = l8('h15, 'h17, 'h19, 'h1b, 'h1d, 'h1f, 'h21, 'h23);
    tbl[2] = mk(1, 802, 4, 3, 1, 3, 0, 3, 0);
    tbl[2].nfa = 3; tbl[2].fa = l8(800, 804, 808); tbl[2].fstrb = 4'b1100;
    tbl[2].nfd = 3; tbl[2].fd = l8(32'hA1B2_0000, 32'hC3D4_0000, 32'hE5F6_0000);
    tbl[3] = mk(0, 32'h1C, 32'hFFFF_FFFC, 3, 2, 4, 0, 3, 0);
    tbl[3].nfa = 3; tbl[3].fa = l8(32'h1C, 32'h18, 32'h14);
    tbl[4] = mk(0, 402, 4, 4, 2, 5, 1, 0, 2);
    tbl[5] = mk(0, 400, 3, 4, 1, 6, 1, 1, 0);
    tbl[5].nfd = 1; tbl[5].fd = l8(32'h0201);
    tbl[6] = mk(1, 123, 4, 0, 0, 7, 0, 0, 2);
    tbl[7] = mk(0, 400, 4, 2, 3, 8, 1, 0, 2);
    tbl[8] = mk(0, 401, 0, 4, 0, 9, 0, 4, 0);
    tbl[8].nfa = 4; tbl[8].fa = l8(400, 400, 400, 400);
    tbl[8].nfd = 4; tbl[8].fd = l8('h02, 'h02, 'h02, 'h02);
    tbl[9] = mk(0, 32'hFFFF_FFF8, 4, 4, 2, 10, 0, 4, 0);
    tbl[9].nfa = 4; tbl[9].fa = l8(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);
    nrows = 10;

    for (int w = 0; w < 256; w++) env_mem[w] = $urandom();
    env_mem[100] = 32'h0403_0201; env_mem[101] = 32'h0807_0605;
    env_mem[102] = 32'h0c0b_0a09; env_mem[103] = 32'h000f_0e0d;
    env_mem[105] = 32'h1817_1615; env_mem[106] = 32'h1c1b_1a19;
    env_mem[107] = 32'h101f_1e1d; env_mem[108] = 32'h2423_2221;
    for (int w = 0; w < 256; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = env_mem[w][8*b +: 8];
    for (int g = 0; g < 32; g++)
      for (int i = 0; i < 32; i++) env_vrf[g][i] = $urandom();
    env_vrf[3][0] = 32'h5A5A_A1B2; env_vrf[3][1] = 32'h5A5A_C3D4; env_vrf[3][2] = 32'h5A5A_E5F6;
    for (int g = 0; g < 32; g++)
      for (int i = 0; i < 32; i++) ref_vrf[g][i] = env_vrf[g][i];

    mem_ready = 1'b0; mem_rdata = '0;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_stride = '0;
    cmd_vl = '0; cmd_sew = '0; cmd_vd = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_vrf_we", 32'(vrf_we), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int t = 0; t < nrows; t++) run_cmd(tbl[t], $sformatf("tbl%0d", t));

    // Reset while a request is stalled in ACCESS.
    hold = 1'b1;
    acc0 = obs_acc.size(); wr0 = obs_wr.size(); dn0 = done_cnt;
    cmd_store = 1'b0; cmd_base = 32'd0; cmd_stride = 32'd4; cmd_vl = 6'd4; cmd_sew = 2'd2;
    cmd_vd = 5'd11; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && !mem_valid; c++) tick();
    chk("rstacc_reached_access", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("rstacc_valid_dropped", 32'(mem_valid), 32'd0);
    chk("rstacc_no_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    hold = 1'b0;
    tick();
    chk("rstacc_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstacc_done_count", 32'(done_cnt - dn0), 32'd0);
    chk("rstacc_traffic", 32'((obs_acc.size() - acc0) + (obs_wr.size() - wr0)), 32'd0);

    for (int k = 0; k < 40; k++) begin
      rv = '0;
      rv.store = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      rv.sew = (r == 9) ? 2'd3 : 2'(r % 3);
      sz = (rv.sew == 2'd0) ? 1 : (rv.sew == 2'd1) ? 2 : 4;
      rv.base = $urandom();
      if ($urandom_range(0, 3) != 0) rv.base = rv.base & ~32'(sz - 1);
      case ($urandom_range(0, 3))
        0: rv.stride = 32'd0;
        1: begin s = int'($urandom_range(0, 16)) - 8; rv.stride = 32'(s * sz); end
        2: rv.stride = $urandom();
        default: begin s = int'($urandom_range(0, 10)) - 5; rv.stride = 32'(s); end
      endcase
      rv.vl = 6'($urandom_range(0, 32));
      rv.vd = 5'($urandom_range(0, 31));
      run_cmd(rv, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_strided_lsu.md
Name: vec_strided_lsu

Overview:
Strided load/store engine of the vector coprocessor (vlse.v / vsse.v). It takes a decoded command (base, stride, vl, SEW, vd) from the pcpi_vec decode stage. It issues one word-aligned memory access per element on the vec_mem_* bus, then writes loaded elements into the vector register file, or reads elements from the VRF for stores. It sits directly upstream of the vector memory port and directly downstream of the instruction decoder.

Parameters:
MAX_VL, 32, maximum elements per command; cmd_vl and the element index are $clog2(MAX_VL)+1 bits wide.
ADDR_W, 32, byte address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE.
cmd_store  in  1  0 = strided load, 1 = strided store.
cmd_base  in  32  byte base address (rs1).
cmd_stride  in  32  signed byte stride (rs2), two's complement.
cmd_vl  in  6  element count, 0..MAX_VL.
cmd_sew  in  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit; 3 is reserved and treated as an error.
cmd_vd  in  5  destination (load) or source (store) vector register.
done  out  1  one-cycle pulse at command completion.
err  out  1  valid with done; 1 = misaligned element or SEW=3.
mem_valid  out  1  memory request.
mem_ready  in  1  one-cycle response strobe.
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
mem_wdata  out  32  store data, lane-shifted.
mem_wstrb  out  4  byte strobes; 0 for loads.
mem_rdata  in  32  read data, valid when mem_ready=1.
vrf_we  out  1  element write strobe.
vrf_reg  out  5  register number (= latched cmd_vd).
vrf_idx  out  6  element index.
vrf_sew  out  2  latched SEW.
vrf_wdata  out  32  element, zero-extended from SEW.
vrf_rdata  in  32  combinational VRF read of (vrf_reg, vrf_idx); element in the low bits.

Behaviour:
- Reset: state=IDLE; mem_valid, mem_wstrb, vrf_we, done, err, idx = 0; cmd_ready=1 on the first cycle after reset. Reset in any state aborts the command with no done pulse. mem_valid is low on the cycle after reset asserts, even if a request is outstanding.
- States: IDLE, CHECK, ACCESS, RESP, FIN.
- IDLE: when cmd_valid=1, latch all cmd_* fields, set idx=0, set addr=cmd_base, and go to CHECK.
- CHECK (1 cycle):
  - If vl=0: go to FIN with err=0, no memory traffic.
  - If SEW=3: go to FIN with err=1.
  - If the current addr is not SEW-aligned (SEW16 needs addr[0]=0; SEW32 needs addr[1:0]=0): go to FIN with err=1. Elements already transferred stay committed.
  - Otherwise go to ACCESS.
- ACCESS: hold mem_valid=1 with stable mem_addr, mem_wdata and mem_wstrb until mem_ready=1, then go to RESP.
  - On mem_ready for a load: capture elem = (mem_rdata >> 8*addr[1:0]) masked to SEW.
  - Store data: mem_wdata = vrf_rdata masked to SEW, shifted left by 8*addr[1:0]. mem_wstrb = {0001, 0011, 1111}[SEW] << addr[1:0].
- RESP (1 cycle, mem_valid=0):
  - Load: vrf_we=1, vrf_idx=idx, vrf_wdata=elem.
  - If idx+1 = vl, go to FIN. Otherwise idx += 1, addr += stride (wraps modulo 2^32), and go to CHECK. Alignment is checked per element.
- FIN: done=1 for one cycle, err as determined; go to IDLE.
- Bus timing: mem_valid is deasserted for at least one cycle after each mem_ready. This is required because the memory ignores a request in its ready cycle. Minimum cost is 4 cycles per element (CHECK, ACCESS×2, RESP).
- stride=0 is legal: every access goes to the same address; for a load, every element gets the same value.
- mem_ready arriving while mem_valid=0 is ignored.

Test Plan:
1. Load, SEW8, base=400, stride=2, vl=8; memory[100..103] = 04030201, 08070605, 0c0b0a09, 000f0e0d -> vrf_wdata for idx 0..7 = 01,03,05,07,09,0b,0d,0f; mem_addr sequence 400,400,404,404,408,408,412,412; done=1, err=0.
2. Load, SEW8, base=420, stride=2, vl=8; memory[105..108] = 18171615, 1c1b1a19, 101f1e1d, 24232221 -> elements 15,17,19,1b,1d,1f,21,23.
3. Store, SEW16, base=802, stride=4, vl=3; VRF elements 0xA1B2, 0xC3D4, 0xE5F6 -> mem_addr 800,804,808; mem_wstrb=1100; mem_wdata=B2A10000-style lane shift (A1B20000, C3D40000, E5F60000); no vrf_we pulses.
4. Load, SEW32, base=0x1C, stride=-4 (0xFFFFFFFC), vl=3 -> mem_addr 0x1C, 0x18, 0x14.
5. SEW32, base=402 -> no mem_valid; done+err after 2 cycles. Separately, SEW16, base=400, stride=3, vl=4 -> idx0 is written, err at idx1, exactly 1 vrf_we.
6. vl=0 -> done, err=0, no bus activity. Separately, reset asserted during ACCESS -> mem_valid=0 next cycle, no done, cmd_ready=1 once reset deasserts.
